gf_sqscl_pipe: RTL and testbench
================================

// Module: gf_sqscl_pipe
// PURPOSE
//  Pipelined, parametrised GF(2^W) squarer-scaler: out = v*(x^2) mod POLY, or x^2 only (per-token mode).
//  Generalises the fixed GF(2^2) combinational square-scale to any W in 2..8, any constant, N stages.
//  Sits in the S-box/inversion datapath; valid/ready on both sides, full throughput, backpressure-safe.
// PARAMETERS
//  W       4         field width in bits, legal 2..8
//  POLY    5'b10011  irreducible field polynomial, W+1 bits, MSB must be 1 (default x^4+x+1)
//  SCL     4'h9      scaling constant v, W bits (default x^3+1)
//  STAGES  2         pipeline register slots, legal 1..4
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  synchronous reset, active-low
//  in_valid   in   1  input token present
//  in_ready   out  1  block accepts token this cycle
//  in_data    in   W  operand x
//  in_sq_only in   1  1: out = x^2; 0: out = v*x^2 (travels with token)
//  out_valid  out  1  result token present
//  out_ready  in   1  downstream accepts result
//  out_data   out  W  result
//  out_par    out  1  even parity of out_data (only with GF_SQSCL_PARITY_EN)
// BEHAVIOUR
//  - Transfer on in_valid&&in_ready (input), out_valid&&out_ready (output); no other event moves data.
//  - Reset (rst_n=0 at posedge): all slot valids=0, slot data=0, out_valid=0, out_data=0, out_par=0.
//    in_ready=0 while rst_n=0; in-flight tokens discarded; first accept on first cycle after release.
//  - Slot k advances when slot k empty or slot k+1 (or output) takes its token this cycle.
//    in_ready = !valid[0] || advance[0]; combinational from out_ready through the chain, no bubbles.
//  - Latency STAGES cycles when out_ready=1; throughput 1 token/cycle; tokens in order, none lost/duplicated.
//  - Math: slot0 computes sq=x^2 mod POLY; last slot applies v*sq mod POLY unless sq_only.
//    STAGES=1: both in slot0. STAGES>2: middle slots pure delay. Products reduced to W bits.
//  - Stall: out_valid&&!out_ready holds out_data/out_par stable until accepted.
//  - Pipeline full and out_ready=0: in_ready=0; in_data/in_sq_only ignored when !in_valid.
//  - Simultaneous accept and emit when full with out_ready=1: both happen, occupancy unchanged.
//  - x=0 yields 0 in both modes; SCL=0 yields 0 unless sq_only.
// CONFIGURATION
//  GF_SQSCL_PARITY_EN defined: out_par port present, = ^out_data, registered with the token,
//    same reset/stall rules as out_data.
//  Undefined: out_par port absent; no parity logic.
// STRUCTURE
//  Shared include aes_types.v: field constants (GF4_POLY=5'b10011, GF2_POLY=3'b111),
//    legal W/STAGES limits, GF_SQSCL_PARITY_EN default (undefined).
//  Functions gf_sq(x,POLY) and gf_mulc(a,v,POLY) live in the include, shared with other GF blocks.
//  Sub-module gf_pipe_slot: one elastic register slot (valid, W+1 data incl. mode bit, advance logic),
//    instantiated STAGES times via generate; top holds the math and the handshake chain.
// TESTING (defaults W=4, POLY=x^4+x+1, SCL=9 unless stated)
//  1 Stream 0,1,2,3,F with out_ready=1, sq_only=0 -> out 0,9,2,B,5 each 2 cycles after accept.
//  2 in=3, sq_only=1 -> out 5; in=F, sq_only=1 -> out A; interleave with mode 0, order preserved.
//  3 Fill pipe, out_ready=0 for 5 cycles -> in_ready=0 once 2 held, out_data stable;
//    release -> all tokens out in order, no loss.
//  4 rst_n=0 with 2 tokens in flight -> next cycle out_valid=0, out_data=0; nothing emitted after.
//  5 W=2, POLY=3'b111, SCL=2, STAGES=1: in 0,1,2,3 -> out 0,2,1,3 with latency 1.
//  6 Exhaustive 0..F, random in_valid/out_ready, STAGES=1..4 vs model; parity checked when
//    GF_SQSCL_PARITY_EN defined.

Source files
------------

// File: rtl/gf_sqscl_pipe_pkg.sv
// Shared GF(2^W) field constants, width limits and constant-multiply helpers.
// Parity output is enabled by defining GF_SQSCL_PARITY_EN (undefined by default).
package gf_sqscl_pipe_pkg;

  localparam int unsigned GF_W_MIN      = 2;
  localparam int unsigned GF_W_MAX      = 8;
  localparam int unsigned GF_STAGES_MIN = 1;
  localparam int unsigned GF_STAGES_MAX = 4;

  localparam logic [4:0] GF4_POLY = 5'b10011;
  localparam logic [2:0] GF2_POLY = 3'b111;

  typedef logic [GF_W_MAX-1:0] gf_elem_t;
  typedef logic [GF_W_MAX:0]   gf_poly_t;

  // Shift-and-add multiply with reduction after each shift; operands must be < 2^w.
  function automatic gf_elem_t gf_mulc(gf_elem_t a, gf_elem_t v, gf_poly_t poly, int unsigned w);
    gf_poly_t aa;
    gf_elem_t acc;
    gf_elem_t vv;
    acc = '0;
    aa  = gf_poly_t'(a);
    vv  = v;
    for (int unsigned i = 0; i < GF_W_MAX; i++) begin
      if (vv[0]) acc ^= aa[GF_W_MAX-1:0];
      vv = vv >> 1;
      aa = aa << 1;
      if ((aa & (gf_poly_t'(1) << w)) != '0) aa ^= poly;
    end
    return acc;
  endfunction

  function automatic gf_elem_t gf_sq(gf_elem_t x, gf_poly_t poly, int unsigned w);
    return gf_mulc(x, x, poly, w);
  endfunction

endpackage

// File: rtl/gf_sqscl_pipe_slot.sv
// One elastic register slot: holds a token until the downstream side takes it,
// and reloads in the same cycle so a full chain still moves one token per cycle.
module gf_sqscl_pipe_slot #(
  parameter int unsigned DW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  input  logic          down_take,
  output logic          advance_c,
  output logic          valid,
  output logic [DW-1:0] data
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    advance_c = !valid_q || down_take;
    valid_d   = valid_q;
    data_d    = data_q;
    if (advance_c) begin
      valid_d = up_valid;
      if (up_valid) data_d = up_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/gf_sqscl_pipe.sv
// Pipelined GF(2^W) squarer-scaler: out = SCL*x^2 mod POLY, or x^2 when sq_only.
// Optional out_par (even parity of out_data) when GF_SQSCL_PARITY_EN is defined.
module gf_sqscl_pipe
  import gf_sqscl_pipe_pkg::*;
#(
  parameter int unsigned    W      = 4,
  parameter logic [W:0]     POLY   = GF4_POLY,
  parameter logic [W-1:0]   SCL    = 4'h9,
  parameter int unsigned    STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_sq_only,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef GF_SQSCL_PARITY_EN
  output logic         out_par,
`endif
  output logic [W-1:0] out_data
);

`ifdef GF_SQSCL_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  // Slot payload: {parity (optional), mode, value}
  localparam int unsigned SW   = W + 1 + PAR_W;
  localparam int unsigned LAST = STAGES - 1;

  function automatic logic [W-1:0] sq_f(logic [W-1:0] x);
    return W'(gf_sq(gf_elem_t'(x), gf_poly_t'(POLY), W));
  endfunction

  function automatic logic [W-1:0] scl_f(logic [W-1:0] s, logic sq_only);
    return sq_only ? s : W'(gf_mulc(gf_elem_t'(s), gf_elem_t'(SCL), gf_poly_t'(POLY), W));
  endfunction

  logic          slot_vin   [STAGES];
  logic [SW-1:0] slot_din   [STAGES];
  logic          slot_take  [STAGES];
  logic          slot_adv   [STAGES];
  logic          slot_valid [STAGES];
  logic [SW-1:0] slot_data  [STAGES];
  logic [W-1:0]  src_val    [STAGES];
  logic          src_mode   [STAGES];
  logic [W-1:0]  dst_val    [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    // Squaring happens on entry to slot 0; middle slots only carry the token.
    if (k == 0) begin : g_head
      assign slot_vin[k] = in_valid;
      assign src_val[k]  = sq_f(in_data);
      assign src_mode[k] = in_sq_only;
    end else begin : g_body
      assign slot_vin[k] = slot_valid[k-1];
      assign src_val[k]  = slot_data[k-1][W-1:0];
      assign src_mode[k] = slot_data[k-1][W];
    end

    // Scaling happens on entry to the output slot; its consumer is the downstream port.
    if (k == LAST) begin : g_tail
      assign dst_val[k]   = scl_f(src_val[k], src_mode[k]);
      assign slot_take[k] = out_ready;
    end else begin : g_mid
      assign dst_val[k]   = src_val[k];
      assign slot_take[k] = slot_adv[k+1];
    end

`ifdef GF_SQSCL_PARITY_EN
    assign slot_din[k] = {(k == LAST) ? ^dst_val[k] : 1'b0, src_mode[k], dst_val[k]};
`else
    assign slot_din[k] = {src_mode[k], dst_val[k]};
`endif

    gf_sqscl_pipe_slot #(
      .DW (SW)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .up_valid  (slot_vin[k]),
      .up_data   (slot_din[k]),
      .down_take (slot_take[k]),
      .advance_c (slot_adv[k]),
      .valid     (slot_valid[k]),
      .data      (slot_data[k])
    );
  end

  // Ready ripples back combinationally from out_ready, so a full pipe never bubbles.
  assign in_ready  = rst_n && slot_adv[0];
  assign out_valid = slot_valid[LAST];
  assign out_data  = slot_data[LAST][W-1:0];

  logic unused_mode_last;
  assign unused_mode_last = slot_data[LAST][W];

`ifdef GF_SQSCL_PARITY_EN
  assign out_par = slot_data[LAST][W+1];

  logic [STAGES-1:0] unused_par;
  for (genvar k = 0; k < STAGES; k++) begin : g_par_sink
    if (k == LAST) begin : g_last
      assign unused_par[k] = 1'b0;
    end else begin : g_other
      assign unused_par[k] = slot_data[k][W+1];
    end
  end
`endif

endmodule

// File: tb/tb_gf_sqscl_pipe.sv
// Self-checking bench for gf_sqscl_pipe: directed vector tables plus randomized
// traffic on STAGES=1..4 instances against a polynomial-division reference model.
module tb_gf_sqscl_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv   [1:4];
  logic       ir   [1:4];
  logic       isq  [1:4];
  logic       ov   [1:4];
  logic       ordy [1:4];
  logic [3:0] id   [1:4];
  logic [3:0] od   [1:4];
`ifdef GF_SQSCL_PARITY_EN
  logic       op   [1:4];
  logic       w2_op;
`endif

  logic       w2_iv, w2_ir, w2_isq, w2_ov, w2_ordy;
  logic [1:0] w2_id, w2_od;

  for (genvar s = 1; s <= 4; s++) begin : g_dut
    gf_sqscl_pipe #(
      .W(4), .POLY(5'b10011), .SCL(4'h9), .STAGES(s)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (iv[s]),
      .in_ready   (ir[s]),
      .in_data    (id[s]),
      .in_sq_only (isq[s]),
      .out_valid  (ov[s]),
      .out_ready  (ordy[s]),
`ifdef GF_SQSCL_PARITY_EN
      .out_par    (op[s]),
`endif
      .out_data   (od[s])
    );
  end

  gf_sqscl_pipe #(
    .W(2), .POLY(3'b111), .SCL(2'h2), .STAGES(1)
  ) u_w2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (w2_iv),
    .in_ready   (w2_ir),
    .in_data    (w2_id),
    .in_sq_only (w2_isq),
    .out_valid  (w2_ov),
    .out_ready  (w2_ordy),
`ifdef GF_SQSCL_PARITY_EN
    .out_par    (w2_op),
`endif
    .out_data   (w2_od)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: carry-less product followed by polynomial long division.
  function automatic int clmul(int a, int b);
    int r = 0;
    for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) r ^= (a << i);
    return r;
  endfunction

  function automatic int pmod(int p, int w, int poly);
    int r = p;
    for (int b = 15; b >= w; b--) if (((r >> b) & 1) != 0) r ^= (poly << (b - w));
    return r;
  endfunction

  function automatic int gf_ref(int x, int sq_only, int w, int poly, int scl);
    int sq = pmod(clmul(x, x), w, poly);
    if (sq_only != 0) return sq;
    return pmod(clmul(scl, sq), w, poly);
  endfunction

  typedef struct {
    logic [3:0] x;
    logic       sq;
    logic [3:0] exp;
  } vec_t;

  vec_t tab4 [8];
  vec_t tab2 [4];

  logic [3:0] exq  [1:4][64];
  int         wp   [1:4];
  int         rp   [1:4];
  int         cnt  [1:4];
  logic       stall[1:4];
  logic [3:0] hold [1:4];

  // Negedge bookkeeping for the randomized phase on all four instances.
  task automatic mon_cycle();
    for (int s = 1; s <= 4; s++) begin
      if (stall[s]) begin
        chk($sformatf("t6_stall_valid_s%0d", s), ov[s], 1);
        chk($sformatf("t6_stall_hold_s%0d", s), od[s], hold[s]);
      end
      if (iv[s] && ir[s]) begin
        exq[s][wp[s] % 64] = 4'(gf_ref(int'(id[s]), int'(isq[s]), 4, 'h13, 9));
        wp[s]++;
        cnt[s]++;
      end
      if (ov[s] && ordy[s]) begin
        chk($sformatf("t6_has_expected_s%0d", s), (wp[s] > rp[s]) ? 1 : 0, 1);
        chk($sformatf("t6_data_s%0d", s), od[s], exq[s][rp[s] % 64]);
`ifdef GF_SQSCL_PARITY_EN
        chk($sformatf("t6_par_s%0d", s), op[s], ^exq[s][rp[s] % 64]);
`endif
        rp[s]++;
      end
      stall[s] = ov[s] && !ordy[s];
      hold[s]  = od[s];
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nf;
    int got;
    logic [3:0] fexp [8];

    tab4[0] = '{4'h0, 1'b0, 4'h0};
    tab4[1] = '{4'h1, 1'b0, 4'h9};
    tab4[2] = '{4'h2, 1'b0, 4'h2};
    tab4[3] = '{4'h3, 1'b0, 4'hB};
    tab4[4] = '{4'hF, 1'b0, 4'h5};
    tab4[5] = '{4'h3, 1'b1, 4'h5};
    tab4[6] = '{4'hF, 1'b1, 4'hA};
    tab4[7] = '{4'h5, 1'b1, 4'h2};
    tab2[0] = '{4'h0, 1'b0, 4'h0};
    tab2[1] = '{4'h1, 1'b0, 4'h2};
    tab2[2] = '{4'h2, 1'b0, 4'h1};
    tab2[3] = '{4'h3, 1'b0, 4'h3};

    rst_n = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      iv[s] = 1'b0; id[s] = '0; isq[s] = 1'b0; ordy[s] = 1'b0;
      wp[s] = 0; rp[s] = 0; cnt[s] = 0; stall[s] = 1'b0; hold[s] = '0;
    end
    w2_iv = 1'b0; w2_id = '0; w2_isq = 1'b0; w2_ordy = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 1; s <= 4; s++) begin
      chk($sformatf("rst_out_valid_s%0d", s), ov[s], 0);
      chk($sformatf("rst_out_data_s%0d", s), od[s], 0);
      chk($sformatf("rst_in_ready_s%0d", s), ir[s], 0);
`ifdef GF_SQSCL_PARITY_EN
      chk($sformatf("rst_out_par_s%0d", s), op[s], 0);
`endif
    end
    chk("rst_w2_out_valid", w2_ov, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Streamed vectors on STAGES=2, full throughput, latency 2
    ordy[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        iv[2] = 1'b1; id[2] = tab4[i].x; isq[2] = tab4[i].sq;
      end else begin
        iv[2] = 1'b0;
      end
      @(negedge clk);
      if (i < 8) chk($sformatf("t1_in_ready_%0d", i), ir[2], 1);
      if (i >= 2) begin
        chk($sformatf("t1_out_valid_%0d", i), ov[2], 1);
        chk($sformatf("t1_out_data_%0d", i - 2), od[2], tab4[i-2].exp);
      end else begin
        chk($sformatf("t1_latency_%0d", i), ov[2], 0);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("t1_idle_after", ov[2], 0);
    @(posedge clk); #1;

    // Fill with out_ready low, hold five cycles, then drain in order
    ordy[2] = 1'b0;
    nf = 0;
    for (int c = 0; c < 7; c++) begin
      iv[2] = 1'b1; id[2] = 4'(7 + c); isq[2] = c[0];
      @(negedge clk);
      if (ir[2]) begin
        fexp[nf] = 4'(gf_ref(7 + c, c & 1, 4, 'h13, 9));
        nf++;
      end
      if (c >= 2) begin
        chk($sformatf("t3_in_ready_full_%0d", c), ir[2], 0);
        chk($sformatf("t3_out_valid_held_%0d", c), ov[2], 1);
        chk($sformatf("t3_out_data_held_%0d", c), od[2], fexp[0]);
      end
      @(posedge clk); #1;
    end
    chk("t3_accepted", nf, 2);
    iv[2] = 1'b0; ordy[2] = 1'b1;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ov[2]) begin
        if (got < nf) chk($sformatf("t3_drain_%0d", got), od[2], fexp[got]);
        got++;
      end
      @(posedge clk); #1;
    end
    chk("t3_drained_count", got, nf);

    // Reset with two tokens in flight
    ordy[2] = 1'b0;
    iv[2] = 1'b1; id[2] = 4'h3; isq[2] = 1'b0;
    @(posedge clk); #1;
    id[2] = 4'h5;
    @(posedge clk); #1;
    iv[2] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t4_out_valid_rst", ov[2], 0);
    chk("t4_out_data_rst", od[2], 0);
    chk("t4_in_ready_rst", ir[2], 0);
    @(posedge clk); #1;
    rst_n = 1'b1; ordy[2] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("t4_no_emit_%0d", c), ov[2], 0);
      @(posedge clk); #1;
    end

    // W=2, SCL=2, STAGES=1: latency 1
    w2_ordy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        w2_iv = 1'b1; w2_id = tab2[i].x[1:0]; w2_isq = tab2[i].sq;
      end else begin
        w2_iv = 1'b0;
      end
      @(negedge clk);
      if (i < 4) chk($sformatf("t5_in_ready_%0d", i), w2_ir, 1);
      if (i >= 1) begin
        chk($sformatf("t5_out_valid_%0d", i), w2_ov, 1);
        chk($sformatf("t5_out_data_%0d", i - 1), w2_od, tab2[i-1].exp[1:0]);
`ifdef GF_SQSCL_PARITY_EN
        chk($sformatf("t5_out_par_%0d", i - 1), w2_op, ^tab2[i-1].exp);
`endif
      end else begin
        chk("t5_latency", w2_ov, 0);
      end
      @(posedge clk); #1;
    end

    // Randomized traffic on STAGES=1..4, operands sweep 0..F repeatedly
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int s = 1; s <= 4; s++) begin
        iv[s]   = ($urandom % 4) != 0;
        id[s]   = 4'(cnt[s]);
        isq[s]  = 1'($urandom % 2);
        ordy[s] = ($urandom % 4) != 0;
      end
      mon_wrap();
    end
    for (int s = 1; s <= 4; s++) begin
      iv[s] = 1'b0; ordy[s] = 1'b1;
    end
    for (int cyc = 0; cyc < 8; cyc++) mon_wrap();
    for (int s = 1; s <= 4; s++) begin
      chk($sformatf("t6_all_out_s%0d", s), rp[s], wp[s]);
      chk($sformatf("t6_enough_tokens_s%0d", s), (cnt[s] >= 32) ? 1 : 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic mon_wrap();
    @(negedge clk);
    mon_cycle();
    @(posedge clk); #1;
  endtask

endmodule
